mem_tx_arbiter: RTL and testbench
=================================

// Module: mem_tx_arbiter
// PURPOSE
//  N-requester arbiter and reply router for the shared serial memory_interface.
//  - Selects one requester (prefetcher, scheduler, DMA, ...) to own the TX channel for each command.
//  - Holds the owner for the whole transaction.
//  - Queues the owner index of every command that expects a reply, and steers RX strobes back
//    to the matching requester in issue order.
//  - Sits between the requesters and memory_interface inside the CPU top level.
// PARAMETERS
//  NUM_REQ         2            number of requesters, 1..8
//  IO_BITS         2            width of tx/rx data per cycle
//  CMD_BITS        `TX_CMD_BITS command header width
//  MAX_OUTSTANDING 3            reply-tracking FIFO depth, >=1
//  RR_MODE         0            0 = fixed priority, index 0 highest; 1 = round-robin
// PORTS
//  clk               in   1                  clock
//  reset_n           in   1                  asynchronous active-low reset
//  req_valid         in   NUM_REQ            requester i has a command ready
//  req_reserve       in   NUM_REQ            requester i claims the next TX slot even without a command
//  req_reply         in   NUM_REQ            requester i's current command expects an RX response
//  req_cmd           in   NUM_REQ*CMD_BITS   packed commands; slice i belongs to requester i
//  req_data          in   NUM_REQ*IO_BITS    packed TX payload data per requester
//  grant             out  NUM_REQ            one-hot current TX owner, or 0
//  tx_command_valid  out  1                  to memory_interface
//  tx_command        out  CMD_BITS           to memory_interface
//  tx_data           out  IO_BITS            to memory_interface
//  tx_command_started in  1                  from memory_interface
//  tx_active          in  1                  from memory_interface
//  rx_done            in  1                  from memory_interface; end of one reply
//  rx_sel            out  NUM_REQ            one-hot owner of the reply at the FIFO head, or 0
//  outstanding       out  $clog2(MAX_OUTSTANDING+1)   number of queued replies
//  fifo_full         out  1                  outstanding == MAX_OUTSTANDING
//  err               out  1                  protocol error flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, reset_n=0): owner register=0, grant=0, FIFO empty, outstanding=0, rr pointer=0, err=0.
//   Reset mid-transaction discards all queued entries; no RX routing afterwards until a new issue.
//  Wanted: want[i] = req_valid[i] | req_reserve[i].
//  Selection, computed combinationally while !tx_active:
//   - If any req_reserve is high: the lowest-index reserver wins.
//   - Else RR_MODE=0: the lowest-index wanter wins.
//   - Else RR_MODE=1: the first wanter at or after rr_ptr wins, scanning upward with wrap.
//  Owner register: loads the selection every cycle while !tx_active; frozen while tx_active.
//  grant = tx_active ? owner register : selection. Zero when nothing is wanted.
//  Mux outputs use the granted index (all zero when grant==0):
//   - tx_command = req_cmd[g], tx_data = req_data[g].
//   - tx_command_valid = req_valid[g] & !(fifo_full & req_reply[g]). Full is a registered flag;
//     a pop in the same cycle does not unblock issue until the next cycle.
//  rr_ptr update: on tx_command_started, rr_ptr <= (g+1) mod NUM_REQ. Unchanged otherwise.
//  FIFO push/pop:
//   - Push index g on tx_command_started & req_reply[g]. Commands without a reply are not queued.
//   - Pop on rx_done & !empty.
//   - Simultaneous push+pop: outstanding unchanged; the head advances correctly, including DEPTH=1.
//   - Pointers wrap modulo MAX_OUTSTANDING.
//  rx_sel = onehot(head entry) when !empty, else 0. Updates the cycle after the pop.
//   Requesters AND rx_sel with the memory_interface rx_* strobes themselves.
//  Error events:
//   - rx_done while empty: ignored; FIFO state unchanged.
//   - tx_command_started while !tx_command_valid: ignored; no push, rr_ptr unchanged.
// CONFIGURATION
//  MEM_ARB_ERR_CHECK_EN defined: err is a sticky register.
//   - Set the cycle after either error event above; cleared only by reset.
//  MEM_ARB_ERR_CHECK_EN undefined: err tied to 0. Error events are still ignored as specified.
// TESTING
//  1. Reset; NUM_REQ=2; req_valid=2'b11, RR_MODE=0 -> grant=2'b01, tx_command=req_cmd[0];
//     after started+done, grant stays 2'b01.
//  2. RR_MODE=1; req_valid=3'b111 held; 3 starts -> granted order 0,1,2,0; rr_ptr wraps.
//  3. req_valid[0]=1, req_reserve[1]=1 -> grant=2'b10 while tx idle; grant frozen while tx_active
//     even if reserve drops.
//  4. MAX_OUTSTANDING=3: issue 3 reply commands from req 1,0,1 -> fifo_full=1, tx_command_valid=0;
//     rx_done x3 -> rx_sel=10,01,10 then 0.
//  5. fifo_full with rx_done and a pending reply command in the same cycle -> no issue that cycle;
//     issue next cycle; outstanding 3->2->3.
//  6. rx_done with empty FIFO -> outstanding stays 0; err=1 next cycle with MEM_ARB_ERR_CHECK_EN,
//     else 0; reset_n pulse mid-tx clears err, grant and FIFO.

Source files
------------

// File: rtl/mem_tx_arbiter.sv
// mem_tx_arbiter
//   Arbitrates NUM_REQ requesters onto the single TX channel of memory_interface,
//   holds the chosen owner for the whole transaction, and tracks the owner of each
//   reply-bearing command in an issue-order FIFO so RX strobes can be steered back.
//
// Parameters
//   NUM_REQ          number of requesters (1..8)
//   IO_BITS          TX/RX data width per cycle
//   CMD_BITS         command header width (defaults to `TX_CMD_BITS)
//   MAX_OUTSTANDING  reply-tracking FIFO depth (>=1)
//   RR_MODE          0 = fixed priority (index 0 highest), 1 = round-robin
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   req_valid           per-requester command ready
//   req_reserve         per-requester claim of the next TX slot (beats plain requests)
//   req_reply           per-requester: current command expects an RX response
//   req_cmd, req_data   packed per-requester command / payload, slice i = requester i
//   grant               one-hot current TX owner, or 0
//   tx_command_valid,
//   tx_command, tx_data to memory_interface
//   tx_command_started,
//   tx_active, rx_done  from memory_interface
//   rx_sel              one-hot owner of the reply at the FIFO head, or 0
//   outstanding         number of queued replies
//   fifo_full           outstanding == MAX_OUTSTANDING
//   err                 sticky protocol error flag
//
// Build option
//   MEM_ARB_ERR_CHECK_EN  when defined, err latches on rx_done with an empty FIFO or
//                         on tx_command_started without tx_command_valid; otherwise
//                         err is tied low. The offending events are ignored either way.

`ifndef TX_CMD_BITS
`define TX_CMD_BITS 8
`endif

module mem_tx_arbiter #(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned IO_BITS         = 2,
  parameter int unsigned CMD_BITS        = `TX_CMD_BITS,
  parameter int unsigned MAX_OUTSTANDING = 3,
  parameter int unsigned RR_MODE         = 0
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ-1:0]                     req_reserve,
  input  logic [NUM_REQ-1:0]                     req_reply,
  input  logic [NUM_REQ*CMD_BITS-1:0]            req_cmd,
  input  logic [NUM_REQ*IO_BITS-1:0]             req_data,
  output logic [NUM_REQ-1:0]                     grant,
  output logic                                   tx_command_valid,
  output logic [CMD_BITS-1:0]                    tx_command,
  output logic [IO_BITS-1:0]                     tx_data,
  input  logic                                   tx_command_started,
  input  logic                                   tx_active,
  input  logic                                   rx_done,
  output logic [NUM_REQ-1:0]                     rx_sel,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   fifo_full,
  output logic                                   err
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_REQ-1:0] want;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_found;
  logic [IDX_W-1:0]   owner_idx;
  logic               owner_any;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               g_valid;
  logic               g_reply;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic               fifo_empty;
  logic               accept;
  logic               push;
  logic               pop;

  assign want = req_valid | req_reserve;

  // Selection: reservations override everything, then fixed priority or round-robin.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    if (|req_reserve) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!sel_found && req_reserve[i]) begin
          sel_found = 1'b1;
          sel_idx   = IDX_W'(i);
        end
      end
    end else if (RR_MODE == 0) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!sel_found && want[i]) begin
          sel_found = 1'b1;
          sel_idx   = IDX_W'(i);
        end
      end
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (!sel_found && want[i] && (i == (32'(rr_ptr) + k) % NUM_REQ)) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
          end
        end
      end
    end
  end

  assign grant_idx = tx_active ? owner_idx : sel_idx;
  assign grant_any = tx_active ? owner_any : sel_found;

  always_comb begin
    grant      = '0;
    tx_command = '0;
    tx_data    = '0;
    g_valid    = 1'b0;
    g_reply    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_any && (grant_idx == IDX_W'(i))) begin
        grant[i]   = 1'b1;
        tx_command = req_cmd[i*CMD_BITS +: CMD_BITS];
        tx_data    = req_data[i*IO_BITS +: IO_BITS];
        g_valid    = req_valid[i];
        g_reply    = req_reply[i];
      end
    end
  end

  // fifo_full comes from the registered count, so a pop only unblocks issue a cycle later.
  assign fifo_full        = (count == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty       = (count == '0);
  assign tx_command_valid = g_valid & ~(fifo_full & g_reply);
  assign outstanding      = count;

  assign accept = tx_command_started & tx_command_valid;
  assign push   = accept & g_reply;
  assign pop    = rx_done & ~fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_idx <= '0;
      owner_any <= 1'b0;
      rr_ptr    <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      if (!tx_active) begin
        owner_idx <= sel_idx;
        owner_any <= sel_found;
      end
      if (accept) begin
        rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (push) begin
        tail <= (tail == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : tail + 1'b1;
      end
      if (pop) begin
        head <= (head == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : head + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only observed through head while count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[tail] <= grant_idx;
    end
  end

  always_comb begin
    rx_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rx_sel[i] = ~fifo_empty & (fifo_mem[head] == IDX_W'(i));
    end
  end

`ifdef MEM_ARB_ERR_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if ((rx_done && fifo_empty) || (tx_command_started && !tx_command_valid)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_tx_arbiter.sv
// tb_mem_tx_arbiter
//   Two instances: a 2-requester fixed-priority arbiter with a 3-deep reply FIFO, and a
//   3-requester round-robin arbiter. Replies are tracked in a scoreboard queue that is
//   filled when a reply command is started and drained on each rx_done.

module tb_mem_tx_arbiter;

`ifdef MEM_ARB_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // fixed-priority instance
  logic [1:0]  fp_valid, fp_reserve, fp_reply;
  logic [15:0] fp_cmd;
  logic [3:0]  fp_data;
  logic [1:0]  fp_grant, fp_rx_sel, fp_outstanding;
  logic        fp_txv, fp_full, fp_err;
  logic [7:0]  fp_tx_cmd;
  logic [1:0]  fp_tx_data;
  logic        fp_started, fp_active, fp_rxdone;

  // round-robin instance
  logic [2:0]  rr_valid, rr_reserve, rr_reply;
  logic [23:0] rr_cmd;
  logic [5:0]  rr_data;
  logic [2:0]  rr_grant, rr_rx_sel;
  logic [1:0]  rr_outstanding;
  logic        rr_txv, rr_full, rr_err;
  logic [7:0]  rr_tx_cmd;
  logic [1:0]  rr_tx_data;
  logic        rr_started, rr_active, rr_rxdone;

  mem_tx_arbiter #(.NUM_REQ(2), .IO_BITS(2), .CMD_BITS(8), .MAX_OUTSTANDING(3), .RR_MODE(0)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .req_valid(fp_valid), .req_reserve(fp_reserve), .req_reply(fp_reply),
    .req_cmd(fp_cmd), .req_data(fp_data),
    .grant(fp_grant), .tx_command_valid(fp_txv), .tx_command(fp_tx_cmd), .tx_data(fp_tx_data),
    .tx_command_started(fp_started), .tx_active(fp_active), .rx_done(fp_rxdone),
    .rx_sel(fp_rx_sel), .outstanding(fp_outstanding), .fifo_full(fp_full), .err(fp_err)
  );

  mem_tx_arbiter #(.NUM_REQ(3), .IO_BITS(2), .CMD_BITS(8), .MAX_OUTSTANDING(2), .RR_MODE(1)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .req_valid(rr_valid), .req_reserve(rr_reserve), .req_reply(rr_reply),
    .req_cmd(rr_cmd), .req_data(rr_data),
    .grant(rr_grant), .tx_command_valid(rr_txv), .tx_command(rr_tx_cmd), .tx_data(rr_tx_data),
    .tx_command_started(rr_started), .tx_active(rr_active), .rx_done(rr_rxdone),
    .rx_sel(rr_rx_sel), .outstanding(rr_outstanding), .fifo_full(rr_full), .err(rr_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int sb[$];        // expected reply owners of u_fp in issue order
  int rr_ptr_m = 0; // model of the round-robin pointer

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [2:0] w, input int ptr);
    for (int k = 0; k < 3; k++) begin
      if (w[(ptr + k) % 3]) return (ptr + k) % 3;
    end
    return -1;
  endfunction

  // One u_fp transaction from a negedge: check grant/valid, start if issuable, 1 active cycle.
  task automatic fp_txn(input int idx, input logic [1:0] valid, input logic [1:0] reply,
                        input logic exp_txv);
    fp_valid = valid;
    fp_reply = reply;
    #1;
    check("fp_grant", 32'(fp_grant), 32'(1) << idx);
    check("fp_txv", 32'(fp_txv), 32'(exp_txv));
    if (exp_txv) begin
      fp_started = 1'b1;
      if (reply[idx]) sb.push_back(idx);
    end
    @(negedge clk);
    fp_started = 1'b0;
    fp_active  = 1'b1;
    @(negedge clk);
    fp_active = 1'b0;
    fp_valid  = '0;
    fp_reply  = '0;
  endtask

  // Pop one reply from a negedge and compare rx_sel against the scoreboard head.
  task automatic fp_rx();
    int exp_idx;
    fp_rxdone = 1'b1;
    #1;
    exp_idx = sb.pop_front();
    check("fp_rx_sel", 32'(fp_rx_sel), 32'(1) << exp_idx);
    @(negedge clk);
    fp_rxdone = 1'b0;
  endtask

  logic [2:0] rr_pat [9];

  initial begin
    int g;
    fp_valid = '0; fp_reserve = '0; fp_reply = '0;
    fp_cmd = {8'hA1, 8'hA0}; fp_data = {2'b10, 2'b01};
    fp_started = 1'b0; fp_active = 1'b0; fp_rxdone = 1'b0;
    rr_valid = '0; rr_reserve = '0; rr_reply = '0;
    rr_cmd = {8'hC2, 8'hC1, 8'hC0}; rr_data = {2'b11, 2'b10, 2'b01};
    rr_started = 1'b0; rr_active = 1'b0; rr_rxdone = 1'b0;
    rr_pat = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b101, 3'b101, 3'b110, 3'b011, 3'b100};

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_grant", 32'(fp_grant), 32'd0);
    check("rst_outstanding", 32'(fp_outstanding), 32'd0);
    check("rst_full", 32'(fp_full), 32'd0);
    check("rst_rx_sel", 32'(fp_rx_sel), 32'd0);
    check("rst_err", 32'(fp_err), 32'd0);
    @(negedge clk);

    // fixed priority picks requester 0; owner frozen while active
    fp_valid = 2'b11;
    #1;
    check("fp_grant0", 32'(fp_grant), 32'd1);
    check("fp_cmd0", 32'(fp_tx_cmd), 32'hA0);
    check("fp_data0", 32'(fp_tx_data), 32'h1);
    check("fp_txv0", 32'(fp_txv), 32'd1);
    fp_started = 1'b1;
    @(negedge clk);
    fp_started = 1'b0;
    fp_active  = 1'b1;
    fp_valid   = 2'b10;
    #1;
    check("fp_frozen", 32'(fp_grant), 32'd1);
    check("fp_cmd_frozen", 32'(fp_tx_cmd), 32'hA0);
    @(negedge clk);
    fp_active = 1'b0;
    fp_valid  = 2'b11;
    #1;
    check("fp_grant_after", 32'(fp_grant), 32'd1);
    check("fp_noreply_out", 32'(fp_outstanding), 32'd0);
    @(negedge clk);

    // reservation beats a plain request, and is held through tx_active
    fp_valid   = 2'b01;
    fp_reserve = 2'b10;
    #1;
    check("fp_resv_grant", 32'(fp_grant), 32'b10);
    check("fp_resv_cmd", 32'(fp_tx_cmd), 32'hA1);
    check("fp_resv_txv", 32'(fp_txv), 32'd0);
    @(negedge clk);
    fp_active  = 1'b1;
    fp_reserve = 2'b00;
    #1;
    check("fp_resv_frozen", 32'(fp_grant), 32'b10);
    @(negedge clk);
    fp_active = 1'b0;
    #1;
    check("fp_resv_release", 32'(fp_grant), 32'b01);
    @(negedge clk);
    fp_valid = '0;

    // fill the reply FIFO from requesters 1,0,1
    fp_txn(1, 2'b10, 2'b10, 1'b1);
    fp_txn(0, 2'b01, 2'b01, 1'b1);
    fp_txn(1, 2'b10, 2'b10, 1'b1);
    #1;
    check("fp_out3", 32'(fp_outstanding), 32'(sb.size()));
    check("fp_full", 32'(fp_full), 32'd1);
    check("fp_head", 32'(fp_rx_sel), 32'(1) << sb[0]);

    // full + rx_done + pending reply command: blocked this cycle, issues next
    fp_valid  = 2'b01;
    fp_reply  = 2'b01;
    fp_rxdone = 1'b1;
    #1;
    check("fp_full_blk_txv", 32'(fp_txv), 32'd0);
    check("fp_full_rx_sel", 32'(fp_rx_sel), 32'(1) << sb.pop_front());
    @(negedge clk);
    fp_rxdone = 1'b0;
    #1;
    check("fp_out2", 32'(fp_outstanding), 32'(sb.size()));
    check("fp_unblk_txv", 32'(fp_txv), 32'd1);
    fp_started = 1'b1;
    sb.push_back(0);
    @(negedge clk);
    fp_started = 1'b0;
    fp_active  = 1'b1;
    #1;
    check("fp_out3b", 32'(fp_outstanding), 32'(sb.size()));
    @(negedge clk);
    fp_active = 1'b0;
    fp_valid  = '0;
    fp_reply  = '0;
    while (sb.size() > 0) fp_rx();
    #1;
    check("fp_drained_sel", 32'(fp_rx_sel), 32'd0);
    check("fp_drained_out", 32'(fp_outstanding), 32'd0);
    @(negedge clk);

    // simultaneous push and pop
    fp_txn(1, 2'b10, 2'b10, 1'b1);
    fp_valid  = 2'b01;
    fp_reply  = 2'b01;
    fp_rxdone = 1'b1;
    #1;
    check("fp_pp_txv", 32'(fp_txv), 32'd1);
    check("fp_pp_sel", 32'(fp_rx_sel), 32'(1) << sb.pop_front());
    fp_started = 1'b1;
    sb.push_back(0);
    @(negedge clk);
    fp_started = 1'b0;
    fp_rxdone  = 1'b0;
    fp_active  = 1'b1;
    #1;
    check("fp_pp_out", 32'(fp_outstanding), 32'(sb.size()));
    check("fp_pp_head", 32'(fp_rx_sel), 32'(1) << sb[0]);
    @(negedge clk);
    fp_active = 1'b0;
    fp_valid  = '0;
    fp_reply  = '0;
    fp_rx();
    #1;
    check("fp_pp_empty", 32'(fp_outstanding), 32'd0);
    check("fp_err_clean", 32'(fp_err), 32'd0);
    @(negedge clk);

    // round-robin order over a table of request patterns
    for (int n = 0; n < 9; n++) begin
      rr_valid = rr_pat[n];
      #1;
      g = rr_pick(rr_pat[n], rr_ptr_m);
      check("rr_grant", 32'(rr_grant), 32'(1) << g);
      check("rr_cmd", 32'(rr_tx_cmd), 32'hC0 + 32'(g));
      rr_started = 1'b1;
      rr_ptr_m   = (g + 1) % 3;
      @(negedge clk);
      rr_started = 1'b0;
      rr_active  = 1'b1;
      @(negedge clk);
      rr_active = 1'b0;
    end

    // start without a valid command: ignored, pointer unchanged
    rr_valid   = 3'b000;
    rr_reserve = 3'b010;
    #1;
    check("rr_resv_grant", 32'(rr_grant), 32'b010);
    check("rr_resv_txv", 32'(rr_txv), 32'd0);
    rr_started = 1'b1;
    @(negedge clk);
    rr_started = 1'b0;
    rr_reserve = 3'b000;
    rr_valid   = 3'b111;
    #1;
    check("rr_bad_start_ptr", 32'(rr_grant), 32'(1) << rr_pick(3'b111, rr_ptr_m));
    check("rr_bad_start_out", 32'(rr_outstanding), 32'd0);
    check("rr_err", 32'(rr_err), 32'(ERR_EN));
    @(negedge clk);
    rr_valid = '0;

    // rx_done with empty FIFO
    fp_rxdone = 1'b1;
    @(negedge clk);
    fp_rxdone = 1'b0;
    #1;
    check("fp_empty_rx_out", 32'(fp_outstanding), 32'd0);
    check("fp_empty_rx_sel", 32'(fp_rx_sel), 32'd0);
    check("fp_err_set", 32'(fp_err), 32'(ERR_EN));
    @(negedge clk);

    // reset pulse mid-transaction
    fp_valid   = 2'b10;
    fp_reply   = 2'b10;
    fp_started = 1'b1;
    sb.push_back(1);
    @(negedge clk);
    fp_started = 1'b0;
    fp_active  = 1'b1;
    #1;
    check("fp_pre_rst_out", 32'(fp_outstanding), 32'd1);
    check("fp_pre_rst_grant", 32'(fp_grant), 32'b10);
    reset_n = 1'b0;
    #1;
    check("fp_rst_grant", 32'(fp_grant), 32'd0);
    check("fp_rst_out", 32'(fp_outstanding), 32'd0);
    check("fp_rst_sel", 32'(fp_rx_sel), 32'd0);
    check("fp_rst_err", 32'(fp_err), 32'd0);
    #1;
    reset_n = 1'b1;
    sb.delete();
    @(negedge clk);
    fp_active = 1'b0;
    fp_valid  = '0;
    fp_reply  = '0;
    fp_rxdone = 1'b1;
    @(negedge clk);
    fp_rxdone = 1'b0;
    #1;
    check("fp_post_rst_out", 32'(fp_outstanding), 32'd0);
    check("fp_post_rst_sel", 32'(fp_rx_sel), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
